// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and helpers for the parameterised sequence detector.
//   DEF_MAX_LEN / DEF_CNT_W / DEF_RST_PAT / DEF_RST_LEN : parameter defaults
//   len_width()  : width of a length field able to hold 0..max_len
//   DEF_LEN_W    : length-field width for the default MAX_LEN
package seq_det_pkg;

  localparam int unsigned DEF_MAX_LEN = 8;
  localparam int unsigned DEF_CNT_W   = 16;
  // Wide enough for the largest legal MAX_LEN; sliced to MAX_LEN by the user.
  localparam logic [31:0] DEF_RST_PAT = 32'h0000_000A;
  localparam int unsigned DEF_RST_LEN = 4;

  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int unsigned DEF_LEN_W = len_width(DEF_MAX_LEN);

endpackage

// File: rtl/seq_match_counter.sv
// seq_match_counter: saturating up-counter for detector matches.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset, clears count
//   inc     : add one on this edge (ignored once the count is all ones)
//   count   : current count, holds at 2^CNT_W-1
module seq_match_counter
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector (Mealy output).
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   din        : serial data bit, sampled when din_valid is high
//   din_valid  : qualifies din; low cycles are transparent gaps
//   pat_load   : latch pat_in/pat_len/overlap_en, clear history; beats din_valid
//   pat_in     : pattern, bit 0 = newest bit, bit len-1 = oldest bit
//   pat_len    : pattern length (0 disables, > MAX_LEN clamps to MAX_LEN)
//   overlap_en : 1 allows overlapping matches
//   dout       : combinational match pulse
//   match_cnt  : saturating match count
// Build option: define SEQ_DETECTOR_PARAM_CNT_EN to implement match_cnt; when
// undefined match_cnt is tied to zero and no counter flops exist.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned        MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned        CNT_W   = DEF_CNT_W,
  parameter logic [MAX_LEN-1:0] RST_PAT = DEF_RST_PAT[MAX_LEN-1:0],
  parameter int unsigned        RST_LEN = DEF_RST_LEN,
  localparam int unsigned       LW      = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               din,
  input  logic               din_valid,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LW-1:0]      pat_len,
  input  logic               overlap_en,
  output logic               dout,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LW-1:0] MaxLenL = LW'(MAX_LEN);
  localparam logic [LW-1:0] RstLenL = LW'(RST_LEN);
  localparam logic [LW:0]   OneW    = (LW + 1)'(1);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      len_clamped;
  logic               fill_ok;
  logic               match;

  // Low len bits of {history, din}; older history beyond MAX_LEN-1 is never compared.
  assign cand = {hist_q[MAX_LEN-2:0], din};
  // Shift by len == MAX_LEN yields all-ones mask.
  assign mask = ~({MAX_LEN{1'b1}} << len_q);
  assign fill_ok = ({1'b0, fill_q} + OneW) >= {1'b0, len_q};
  assign len_clamped = (pat_len > MaxLenL) ? MaxLenL : pat_len;

  assign match = din_valid && !pat_load && (len_q != '0) && fill_ok &&
                 (((cand ^ pat_q) & mask) == '0);
  assign dout = match;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    if (pat_load) begin
      pat_d  = pat_in;
      len_d  = len_clamped;
      ovl_d  = overlap_en;
      hist_d = '0;
      fill_d = '0;
    end else if (din_valid) begin
      hist_d = cand;
      if (match && !ovl_q) begin
        // Non-overlap: discard the matched bits so none can count twice.
        fill_d = '0;
      end else if (fill_q != MaxLenL) begin
        fill_d = fill_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= RST_PAT;
      len_q  <= RstLenL;
      ovl_q  <= 1'b1;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
    end
  end

`ifdef SEQ_DETECTOR_PARAM_CNT_EN
  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (match),
    .count   (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed self-checking bench for seq_detector_param.
// A second instance with CNT_W=2 shares all inputs to exercise counter saturation.
module tb_seq_detector_param;
  import seq_det_pkg::*;

  localparam int unsigned LW = len_width(DEF_MAX_LEN);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          din;
  logic          din_valid;
  logic          pat_load;
  logic [7:0]    pat_in;
  logic [LW-1:0] pat_len;
  logic          overlap_en;
  logic          dout;
  logic          dout2;
  logic [15:0]   match_cnt;
  logic [1:0]    match_cnt2;

  int total   = 0;
  int bad     = 0;
  int n_match = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .pat_len    (pat_len),
    .overlap_en (overlap_en),
    .dout       (dout),
    .match_cnt  (match_cnt)
  );

  seq_detector_param #(
    .CNT_W (2)
  ) dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .pat_len    (pat_len),
    .overlap_en (overlap_en),
    .dout       (dout2),
    .match_cnt  (match_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected count: matches seen so far, saturated, or zero when the counter is built out.
  function automatic int exp_cnt(input int sat);
`ifdef SEQ_DETECTOR_PARAM_CNT_EN
    return (n_match > sat) ? sat : n_match;
`else
    return 0;
`endif
  endfunction

  task automatic check_cnt(input string tag);
    chk({tag, "_cnt"}, 32'(match_cnt), 32'(exp_cnt(65535)));
    chk({tag, "_cnt2"}, 32'(match_cnt2), 32'(exp_cnt(3)));
  endtask

  // One valid bit; inputs change 1 time unit after posedge, dout sampled at negedge.
  task automatic send(input logic b, input logic exp_d, input string tag);
    din       = b;
    din_valid = 1'b1;
    @(negedge clk);
    chk(tag, 32'(dout), 32'(exp_d));
    chk({tag, "_i2"}, 32'(dout2), 32'(exp_d));
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    if (exp_d) n_match++;
  endtask

  // bits[0] is sent first; exp[i] is the dout expected on bit i.
  task automatic run(input logic [15:0] bits, input logic [15:0] exp, input int n,
                     input string tag);
    for (int i = 0; i < n; i++) begin
      send(bits[i], exp[i], $sformatf("%s_b%0d", tag, i + 1));
    end
  endtask

  task automatic gap(input int n, input string tag);
    din_valid = 1'b0;
    din       = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s_g%0d", tag, i), 32'(dout), 32'(0));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [7:0] p, input logic [LW-1:0] l, input logic ovl,
                      input logic with_valid, input string tag);
    pat_in     = p;
    pat_len    = l;
    overlap_en = ovl;
    pat_load   = 1'b1;
    din_valid  = with_valid;
    din        = 1'b1;
    @(negedge clk);
    chk({tag, "_load"}, 32'(dout), 32'(0));
    @(posedge clk);
    #1;
    pat_load  = 1'b0;
    din_valid = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    pat_load   = 1'b0;
    pat_in     = '0;
    pat_len    = '0;
    overlap_en = 1'b0;
    #2;
    chk("rst_dout", 32'(dout), 32'(0));
    check_cnt("rst");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset pattern 1010 with overlap: stream 1,0,1,0,1,0 -> hits on bits 4 and 6.
    run(16'b010101, 16'b101000, 6, "def");
    check_cnt("def");

    // 1010 without overlap: 1,0,1,0,1,0,1,0 -> hits on bits 4 and 8 only.
    load(8'h0A, LW'(4), 1'b0, 1'b0, "novl");
    run(16'b01010101, 16'b10001000, 8, "novl");
    check_cnt("novl");

    // Same pattern split by 3-cycle gaps; gap din=1 must not be sampled.
    send(1'b1, 1'b0, "gap_b1");
    gap(3, "gap1");
    send(1'b0, 1'b0, "gap_b2");
    gap(3, "gap2");
    send(1'b1, 1'b0, "gap_b3");
    gap(3, "gap3");
    send(1'b0, 1'b1, "gap_b4");
    check_cnt("gap");

    // 111 with overlap: five 1s -> hits on bits 3, 4 and 5.
    load(8'h07, LW'(3), 1'b1, 1'b0, "p111");
    run(16'b11111, 16'b11100, 5, "p111");
    check_cnt("p111");
    // Load with a would-match valid bit: no pulse, history restarts.
    load(8'h07, LW'(3), 1'b1, 1'b1, "ldv");
    run(16'b111, 16'b100, 3, "ldv");
    check_cnt("ldv");

    // Length 15 clamps to 8: eight 1s match on the eighth.
    load(8'hFF, LW'(15), 1'b1, 1'b0, "clamp");
    run(16'hFF, 16'h80, 8, "clamp");
    check_cnt("clamp");

    // Length 0 disables matching.
    load(8'h00, LW'(0), 1'b1, 1'b0, "len0");
    run(16'h0000, 16'h0000, 4, "len0");
    check_cnt("len0");

    // Reset mid-pattern: partial 1,0,1 is lost, reset config (1010, overlap) returns.
    load(8'h0A, LW'(4), 1'b0, 1'b0, "prst");
    run(16'b101, 16'b000, 3, "prst");
    reset_n   = 1'b0;
    din       = 1'b0;
    din_valid = 1'b1;
    n_match   = 0;
    @(negedge clk);
    chk("inrst_dout", 32'(dout), 32'(0));
    check_cnt("inrst");
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    reset_n   = 1'b1;
    send(1'b0, 1'b0, "post_0");
    run(16'b010101, 16'b101000, 6, "post");
    check_cnt("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits (2..32).
REQ-002 SHALL have parameter CNT_W, default 16: match counter width.
REQ-003 SHALL have parameter RST_PAT, default 8'b0000_1010: pattern after reset, MAX_LEN bits wide.
REQ-004 SHALL have parameter RST_LEN, default 4: pattern length after reset.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port din, input, 1: serial data bit.
REQ-008 SHALL have port din_valid, input, 1: din is sampled only when this is high.
REQ-009 SHALL have port pat_load, input, 1: load pat_in, pat_len and overlap_en into the configuration registers.
REQ-010 SHALL have port pat_in, input, MAX_LEN: new pattern; bit 0 = newest bit, bit len-1 = oldest bit.
REQ-011 SHALL have port pat_len, input, $clog2(MAX_LEN+1): new pattern length.
REQ-012 SHALL have port overlap_en, input, 1: 1 allows overlapping matches, 0 forbids them.
REQ-013 SHALL have port dout, output, 1: Mealy match pulse.
REQ-014 SHALL have port match_cnt, output, CNT_W: saturating count of matches.

Function
REQ-015 SHALL keep these state registers: history (last MAX_LEN accepted bits), fill count (0..MAX_LEN), active pattern, active length and active overlap mode.
REQ-016 SHALL assert dout combinationally in the same cycle when all of the following hold: din_valid=1, pat_load=0, fill+1 >= len, and the low len bits of {history,din} equal the low len bits of the pattern.
REQ-017 SHALL, on an edge with din_valid=1 and pat_load=0, shift din into history bit 0 and increment fill, saturating at MAX_LEN.
REQ-018 SHALL, on a match edge with overlap mode 0, clear fill to 0 so that no bit of a matched sequence is reused; with overlap mode 1, fill continues normally.
REQ-019 SHALL, when din_valid=0, hold history and fill and drive dout=0 (gaps are transparent).
REQ-020 SHALL, on an edge with pat_load=1, latch the pattern, length and mode and clear history and fill; pat_load takes priority over a simultaneous din_valid, whose bit is discarded and cannot match.
REQ-021 SHALL treat len=0 as disabled (dout never asserted) and clamp len > MAX_LEN to MAX_LEN at load.
REQ-022 SHALL increment match_cnt by 1 on every edge where dout=1, holding at 2^CNT_W-1 (no wrap).
REQ-023 SHALL leave match_cnt unchanged on pat_load.

Reset
REQ-024 SHALL, while reset_n=0, asynchronously set history=0, fill=0, pattern=RST_PAT, len=RST_LEN, overlap mode=1 and match_cnt=0; dout SHALL be 0.
REQ-025 SHALL start matching on the first valid bit after reset_n deasserts; bits in flight when reset asserts are discarded.

Configuration
REQ-026 SHALL support the macro SEQ_DETECTOR_PARAM_CNT_EN: when it is defined, match_cnt is implemented per REQ-022.
REQ-027 SHALL, when SEQ_DETECTOR_PARAM_CNT_EN is undefined, tie match_cnt to 0, instantiate no counter flops, and leave the port list unchanged.

Structure
REQ-028 SHALL place the MAX_LEN/CNT_W/RST_PAT/RST_LEN defaults and the length-width helper constant in shared package seq_det_pkg.
REQ-029 SHALL implement the saturating counter as sub-module seq_match_counter (inputs: clk, reset_n, inc; output: count[CNT_W-1:0]), instantiated only under SEQ_DETECTOR_PARAM_CNT_EN.

Verification
REQ-030 SHALL cover: reset defaults (1010, overlap), valid stream 1,0,1,0,1,0 -> dout high on bits 4 and 6, match_cnt=2.
REQ-031 SHALL cover: load 1010 with overlap_en=0, stream 1,0,1,0,1,0,1,0 -> dout on bits 4 and 8 only, match_cnt=2.
REQ-032 SHALL cover: the bits of 1010 interleaved with din_valid=0 gaps of 3 cycles -> exactly one dout pulse on the final valid 0, and dout=0 during the gaps.
REQ-033 SHALL cover: load len=3 pattern 111 with overlap_en=1, stream of five 1s -> dout on bits 3, 4 and 5; pat_load with din_valid=1 on bit 5 -> no pulse and the history is cleared.
REQ-034 SHALL cover: with CNT_W=2, 5 matches -> match_cnt sticks at 3; macro undefined -> match_cnt=0 throughout.
REQ-035 SHALL cover: reset_n pulsed low after 1,0,1 -> the following 0 gives no match, and a fresh 1,0,1,0 matches.
